seven_sd_scan_capture: RTL and testbench

Receive-side counterpart of the seven-segment multiplex driver. It samples the active-low digit enables and segment lines that a scanning driver produces, waits until each digit has settled, and rebuilds the 32-bit segment word the driver was given. It also decodes each byte to a hex nibble where the pattern is a legal hex glyph. It sits in the tester's loopback path, fed from the driver outputs or from the board pins, so the tester can check what the display actually shows.

---
 rtl/seven_sd_pkg.sv | 83 ++++++++
 rtl/seven_sd_scan_capture_sync2.sv | 25 ++
 rtl/seven_sd_scan_capture.sv | 184 ++++++++++++++++++
 tb/tb_seven_sd_scan_capture.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_sd_pkg.sv
// Shared definitions for the seven-segment scan driver and its capture counterpart:
// active-low glyph constants, enable-to-digit mapping and glyph decode.
package seven_sd_pkg;

    // Active-low segment patterns (dp bit held high) for hex digits 0..F
    localparam logic [7:0] GLYPH_0 = 8'hC0;
    localparam logic [7:0] GLYPH_1 = 8'hF9;
    localparam logic [7:0] GLYPH_2 = 8'hA4;
    localparam logic [7:0] GLYPH_3 = 8'hB0;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h92;
    localparam logic [7:0] GLYPH_6 = 8'h82;
    localparam logic [7:0] GLYPH_7 = 8'hF8;
    localparam logic [7:0] GLYPH_8 = 8'h80;
    localparam logic [7:0] GLYPH_9 = 8'h90;
    localparam logic [7:0] GLYPH_A = 8'h88;
    localparam logic [7:0] GLYPH_B = 8'h83;
    localparam logic [7:0] GLYPH_C = 8'hC6;
    localparam logic [7:0] GLYPH_D = 8'hA1;
    localparam logic [7:0] GLYPH_E = 8'h86;
    localparam logic [7:0] GLYPH_F = 8'h8E;

    // Active-low digit enables, one per digit position
    localparam logic [3:0] EN_DIGIT0 = 4'b0111;
    localparam logic [3:0] EN_DIGIT1 = 4'b1110;
    localparam logic [3:0] EN_DIGIT2 = 4'b1101;
    localparam logic [3:0] EN_DIGIT3 = 4'b1011;

    typedef struct packed {
        logic       valid;
        logic [3:0] nibble;
    } glyph_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } digit_t;

    // Map an enable pattern to its digit index; valid only for the four single-low patterns
    function automatic digit_t enable_to_digit(input logic [3:0] en);
        digit_t d;
        d.valid = 1'b1;
        d.idx   = 2'd0;
        case (en)
            EN_DIGIT0: d.idx = 2'd0;
            EN_DIGIT1: d.idx = 2'd1;
            EN_DIGIT2: d.idx = 2'd2;
            EN_DIGIT3: d.idx = 2'd3;
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

    // Decode an active-low segment byte to a hex nibble; the decimal point is ignored
    function automatic glyph_t glyph_decode(input logic [7:0] seg);
        glyph_t     g;
        logic [7:0] m;
        m        = seg | 8'h80;
        g.valid  = 1'b1;
        g.nibble = 4'h0;
        case (m)
            GLYPH_0: g.nibble = 4'h0;
            GLYPH_1: g.nibble = 4'h1;
            GLYPH_2: g.nibble = 4'h2;
            GLYPH_3: g.nibble = 4'h3;
            GLYPH_4: g.nibble = 4'h4;
            GLYPH_5: g.nibble = 4'h5;
            GLYPH_6: g.nibble = 4'h6;
            GLYPH_7: g.nibble = 4'h7;
            GLYPH_8: g.nibble = 4'h8;
            GLYPH_9: g.nibble = 4'h9;
            GLYPH_A: g.nibble = 4'hA;
            GLYPH_B: g.nibble = 4'hB;
            GLYPH_C: g.nibble = 4'hC;
            GLYPH_D: g.nibble = 4'hD;
            GLYPH_E: g.nibble = 4'hE;
            GLYPH_F: g.nibble = 4'hF;
            default: g.valid  = 1'b0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seven_sd_scan_capture_sync2.sv
// Parameterized-width two-flop synchronizer with an asynchronous reset value.
module sync2 #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops to resolve metastability on asynchronous pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/seven_sd_scan_capture.sv
// Samples a multiplexed seven-segment scan, waits for each digit to settle and
// rebuilds the 32-bit segment word plus per-digit hex decode and frame status.
module seven_sd_scan_capture
    import seven_sd_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  enableIn,
    input  logic [7:0]  displayIn,
    output logic [31:0] signals,
    output logic [15:0] hexDigits,
    output logic [3:0]  hexValid,
    output logic        frameValid,
    output logic        frameStrobe,
    output logic        scanError
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_ARM   = CNT_W'(STABLE_CYCLES - 2);
    localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETTLE   = 2'd1;
    localparam logic [1:0] ST_CAPTURED = 2'd2;

    logic [11:0]      sync_q;
    logic [11:0]      prev_q;
    logic [3:0]       en_s;
    logic [7:0]       seg_s;
    logic             changed;
    digit_t           en_dec;
    logic             one_low;
    logic             multi_low;
    logic [1:0]       state;
    logic [CNT_W-1:0] stab_cnt;
    logic [CNT_W-1:0] stab_next;
    logic [CNT_W-1:0] err_cnt;
    logic             capture_go;
    logic             cap_pend;
    logic [1:0]       cap_idx;
    logic [7:0]       cap_seg;
    glyph_t           cap_glyph;
    logic [3:0]       seen_mask;
    logic [3:0]       seen_next;
    logic [TMO_W-1:0] tmo_cnt;

    // Idle display (all lines high) is the reset value so reset never looks like a capture
    sync2 #(
        .WIDTH       (12),
        .RESET_VALUE (12'hFFF)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({enableIn, displayIn}),
        .q   (sync_q)
    );

    assign en_s      = sync_q[11:8];
    assign seg_s     = sync_q[7:0];
    assign changed   = (sync_q != prev_q);
    assign en_dec    = enable_to_digit(en_s);
    assign one_low   = en_dec.valid;
    assign multi_low = ($countones(~en_s) > 32'd1);

    // Unchanged cycles so far, counting the current one; IDLE restarts the count at 1
    assign stab_next  = (state == ST_SETTLE) ? (stab_cnt + 1'b1) : CNT_W'(1);
    assign capture_go = !changed && one_low && (state != ST_CAPTURED) && (stab_next == STAB_LAST);

    assign cap_glyph = glyph_decode(cap_seg);
    assign seen_next = seen_mask | (4'b0001 << cap_idx);

    // Settle FSM: track how long the single-enable pattern has held unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= 12'hFFF;
            state    <= ST_IDLE;
            stab_cnt <= '0;
            cap_pend <= 1'b0;
        end else begin
            prev_q   <= sync_q;
            cap_pend <= capture_go;
            if (changed) begin
                state    <= ST_IDLE;
                stab_cnt <= '0;
            end else begin
                case (state)
                    ST_IDLE, ST_SETTLE: begin
                        if (!one_low) begin
                            state    <= ST_IDLE;
                            stab_cnt <= '0;
                        end else if (capture_go) begin
                            state    <= ST_CAPTURED;
                            stab_cnt <= stab_next;
                        end else begin
                            state    <= ST_SETTLE;
                            stab_cnt <= stab_next;
                        end
                    end
                    ST_CAPTURED: begin
                        state <= ST_CAPTURED;
                    end
                    default: begin
                        state    <= ST_IDLE;
                        stab_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Latch the settled digit on entry to CAPTURED; cap_pend gates its use
    always_ff @(posedge clk) begin
        if (capture_go) begin
            cap_idx <= en_dec.idx;
            cap_seg <= seg_s;
        end
    end

    // Registered write of the captured byte and its hex decode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            signals   <= 32'hFFFF_FFFF;
            hexDigits <= 16'h0000;
            hexValid  <= 4'h0;
        end else if (cap_pend) begin
            signals[{cap_idx, 3'b000} +: 8]   <= cap_seg;
            hexDigits[{cap_idx, 2'b00} +: 4]  <= cap_glyph.nibble;
            hexValid[cap_idx]                 <= cap_glyph.valid;
        end
    end

    // Count cycles of a stable multi-enable pattern; any such dwell latches scanError
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt   <= '0;
            scanError <= 1'b0;
        end else if (changed || !multi_low) begin
            err_cnt <= '0;
        end else begin
            if (err_cnt != STAB_LAST) begin
                err_cnt <= err_cnt + 1'b1;
            end
            if (err_cnt == ERR_ARM) begin
                scanError <= 1'b1;
            end
        end
    end

    // Frame completion and capture timeout; a capture in the timeout cycle takes priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seen_mask   <= 4'h0;
            frameValid  <= 1'b0;
            frameStrobe <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            frameStrobe <= 1'b0;
            if (cap_pend) begin
                tmo_cnt <= '0;
                if (seen_next == 4'hF) begin
                    frameStrobe <= 1'b1;
                    frameValid  <= 1'b1;
                    seen_mask   <= 4'h0;
                end else begin
                    seen_mask <= seen_next;
                end
            end else if (tmo_cnt >= TMO_LAST) begin
                tmo_cnt    <= TMO_MAX;
                frameValid <= 1'b0;
                seen_mask  <= 4'h0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seven_sd_scan_capture.sv
// Bench for seven_sd_scan_capture: reset values, directed vector table,
// multi-cycle corner sequences and a randomized run against a pin-level model.
module tb_seven_sd_scan_capture;

    localparam int S = 4;
    localparam int T = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  enableIn;
    logic [7:0]  displayIn;
    logic [31:0] signals;
    logic [15:0] hexDigits;
    logic [3:0]  hexValid;
    logic        frameValid;
    logic        frameStrobe;
    logic        scanError;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seven_sd_scan_capture #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enableIn    (enableIn),
        .displayIn   (displayIn),
        .signals     (signals),
        .hexDigits   (hexDigits),
        .hexValid    (hexValid),
        .frameValid  (frameValid),
        .frameStrobe (frameStrobe),
        .scanError   (scanError)
    );

    // ---------------- reference model (pin-sample level) ----------------
    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [3:0] onehot_tab [4] = '{4'b0111, 4'b1110, 4'b1101, 4'b1011};

    typedef struct {
        int         at;
        logic [3:0] en;
        logic [7:0] seg;
    } ev_t;

    ev_t        cap_q[$];
    int         err_q[$];
    int         edge_n;
    logic [11:0] m_prev;
    int         m_run;
    int         m_age;
    logic [31:0] m_sig;
    logic [15:0] m_hex;
    logic [3:0]  m_hv;
    logic [3:0]  m_seen;
    logic        m_fv;
    logic        m_strobe;
    logic        m_scan;
    bit          sb_on = 1'b0;

    function automatic int digit_of(input logic [3:0] e);
        for (int k = 0; k < 4; k++) begin
            if (onehot_tab[k] == e) return k;
        end
        return -1;
    endfunction

    function automatic int zeros(input logic [3:0] e);
        int z = 0;
        for (int k = 0; k < 4; k++) begin
            if (!e[k]) z++;
        end
        return z;
    endfunction

    task automatic model_reset();
        cap_q.delete();
        err_q.delete();
        edge_n   = 0;
        m_prev   = 12'hFFF;
        m_run    = 0;
        m_age    = 0;
        m_sig    = 32'hFFFF_FFFF;
        m_hex    = 16'h0;
        m_hv     = 4'h0;
        m_seen   = 4'h0;
        m_fv     = 1'b0;
        m_strobe = 1'b0;
        m_scan   = 1'b0;
    endtask

    // One rising edge: sample the pins, schedule settled events, apply due ones
    task automatic model_edge();
        logic [11:0] s;
        bit          cap;
        ev_t         e;
        int          d;
        int          nib;
        bit          ok;
        edge_n++;
        s = {enableIn, displayIn};
        if (s == m_prev) m_run++;
        else m_run = 1;
        m_prev = s;
        if (m_run == S) begin
            if (digit_of(s[11:8]) >= 0) cap_q.push_back('{edge_n + 3, s[11:8], s[7:0]});
            else if (zeros(s[11:8]) >= 2) err_q.push_back(edge_n + 2);
        end
        m_strobe = 1'b0;
        while (err_q.size() > 0 && err_q[0] <= edge_n) begin
            void'(err_q.pop_front());
            m_scan = 1'b1;
        end
        cap = 1'b0;
        if (cap_q.size() > 0 && cap_q[0].at == edge_n) begin
            e   = cap_q.pop_front();
            cap = 1'b1;
            d   = digit_of(e.en);
            ok  = 1'b0;
            nib = 0;
            for (int k = 0; k < 16; k++) begin
                if ((e.seg | 8'h80) == glyph_tab[k]) begin
                    ok  = 1'b1;
                    nib = k;
                end
            end
            m_sig[8*d +: 8] = e.seg;
            m_hex[4*d +: 4] = 4'(nib);
            m_hv[d]         = ok;
            m_seen[d]       = 1'b1;
            if (m_seen == 4'hF) begin
                m_strobe = 1'b1;
                m_fv     = 1'b1;
                m_seen   = 4'h0;
            end
            m_age = 0;
        end
        if (!cap) begin
            m_age++;
            if (m_age == T) begin
                m_fv   = 1'b0;
                m_seen = 4'h0;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (sb_on) begin
            chk("scoreboard", {9'd0, signals, hexDigits, hexValid, frameValid, frameStrobe, scanError},
                {9'd0, m_sig, m_hex, m_hv, m_fv, m_strobe, m_scan});
        end
    endtask

    task automatic drive(input logic [3:0] en, input logic [7:0] seg);
        enableIn  = en;
        displayIn = seg;
    endtask

    // Called just after a rising edge; checks the asynchronous clear before the next edge
    task automatic apply_reset();
        rst = 1'b1;
        #2;
        model_reset();
        chk("reset_signals", {32'd0, signals}, 64'hFFFF_FFFF);
        chk("reset_hex", {48'd0, hexDigits}, 64'd0);
        chk("reset_flags", {58'd0, hexValid, frameValid, frameStrobe}, 64'd0);
        chk("reset_scanerr", {63'd0, scanError}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  en;
        logic [7:0]  disp;
        int          hold;
        logic [31:0] sig;
        logic [15:0] hex;
        logic [3:0]  hv;
        logic        fv;
        int          strobes;
    } vec_t;

    vec_t vecs[8];

    task automatic run_vec(input int i);
        int n_str = 0;
        drive(vecs[i].en, vecs[i].disp);
        repeat (vecs[i].hold) begin
            tick();
            if (frameStrobe) n_str++;
        end
        chk($sformatf("vec%0d_signals", i), {32'd0, signals}, {32'd0, vecs[i].sig});
        chk($sformatf("vec%0d_hex", i), {48'd0, hexDigits}, {48'd0, vecs[i].hex});
        chk($sformatf("vec%0d_hexvalid", i), {60'd0, hexValid}, {60'd0, vecs[i].hv});
        chk($sformatf("vec%0d_framevalid", i), {63'd0, frameValid}, {63'd0, vecs[i].fv});
        chk($sformatf("vec%0d_strobes", i), 64'(n_str), 64'(vecs[i].strobes));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        logic [3:0] en;
        logic [7:0] seg;
        int  hold;

        vecs[0] = '{4'b0111, 8'hF9, 8, 32'hFFFF_FFF9, 16'h0001, 4'h1, 1'b0, 0};
        vecs[1] = '{4'b1110, 8'hA4, 8, 32'hFFFF_A4F9, 16'h0021, 4'h3, 1'b0, 0};
        vecs[2] = '{4'b1101, 8'hB0, 8, 32'hFFB0_A4F9, 16'h0321, 4'h7, 1'b0, 0};
        vecs[3] = '{4'b1011, 8'h99, 8, 32'h99B0_A4F9, 16'h4321, 4'hF, 1'b1, 1};
        vecs[4] = '{4'b1110, 8'h86, 8, 32'h99B0_86F9, 16'h43E1, 4'hF, 1'b1, 0};
        vecs[5] = '{4'b0111, 8'hFF, 8, 32'h99B0_86FF, 16'h43E0, 4'hE, 1'b1, 0};
        vecs[6] = '{4'b1101, 8'h7F, 8, 32'h997F_86FF, 16'h40E0, 4'hA, 1'b1, 0};
        vecs[7] = '{4'b1011, 8'h40, 8, 32'h407F_86FF, 16'h00E0, 4'hA, 1'b1, 1};

        rst = 1'b1;
        drive(4'b1111, 8'hFF);
        model_reset();
        @(posedge clk);
        #1;
        apply_reset();

        // Capture latency: first sampling edge is tick 1, write lands on tick 7
        drive(4'b0111, 8'hC0);
        repeat (6) tick();
        chk("latency_before", {32'd0, signals}, 64'hFFFF_FFFF);
        tick();
        chk("latency_signals", {32'd0, signals}, 64'hFFFF_FFC0);
        chk("latency_hex", {48'd0, hexDigits}, 64'h0);
        chk("latency_hexvalid", {60'd0, hexValid}, 64'h1);
        repeat (3) tick();

        for (int i = 0; i < 4; i++) run_vec(i);

        // Fast toggling never settles
        for (int k = 0; k < 8; k++) begin
            drive(4'b1110, (k % 2 == 0) ? 8'h12 : 8'h34);
            repeat (2) tick();
        end
        chk("toggle_signals", {32'd0, signals}, 64'h99B0_A4F9);

        for (int i = 4; i < 8; i++) run_vec(i);

        // Several enables low: error latches, nothing captured, captures then resume
        drive(4'b0011, 8'h55);
        repeat (10) tick();
        chk("multi_scanerr", {63'd0, scanError}, 64'd1);
        chk("multi_signals", {32'd0, signals}, 64'h407F_86FF);
        drive(4'b0111, 8'hC0);
        repeat (8) tick();
        chk("resume_signals", {32'd0, signals}, 64'h407F_86C0);
        chk("resume_hexvalid", {60'd0, hexValid}, 64'hB);
        chk("resume_scanerr", {63'd0, scanError}, 64'd1);

        // Complete a frame, then go dark and time the frameValid drop
        drive(4'b1110, 8'hF9);
        repeat (8) tick();
        drive(4'b1101, 8'hA4);
        repeat (8) tick();
        drive(4'b1011, 8'hB0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            tick();
            if (frameStrobe) seen = 1'b1;
        end
        chk("frame_strobe_seen", {63'd0, seen}, 64'd1);
        chk("frame_valid_set", {63'd0, frameValid}, 64'd1);
        drive(4'b1111, 8'hFF);
        n = 0;
        while (frameValid && n < 100) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'(T));
        chk("timeout_retained", {32'd0, signals}, 64'hB0A4_F9C0);

        // Reset in the middle of a settle; the next capture needs a full settle
        drive(4'b1110, 8'h86);
        repeat (3) tick();
        apply_reset();
        repeat (6) tick();
        chk("post_reset_wait", {32'd0, signals}, 64'hFFFF_FFFF);
        tick();
        chk("post_reset_signals", {32'd0, signals}, 64'hFFFF_86FF);
        chk("post_reset_hex", {48'd0, hexDigits}, 64'h00E0);
        chk("post_reset_hexvalid", {60'd0, hexValid}, 64'h2);

        // Randomized scan traffic against the model
        drive(4'b1111, 8'hFF);
        tick();
        apply_reset();
        sb_on = 1'b1;
        for (int it = 0; it < 300; it++) begin
            n = $urandom_range(0, 99);
            if (n < 65) begin
                en = onehot_tab[$urandom_range(0, 3)];
            end else if (n < 75) begin
                en = 4'($urandom_range(0, 15));
                while (zeros(en) < 2) en = 4'($urandom_range(0, 15));
            end else if (n < 85) begin
                en = 4'b1111;
            end else begin
                en = 4'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 1) == 0) begin
                seg = glyph_tab[$urandom_range(0, 15)];
                if ($urandom_range(0, 3) == 0) seg = seg & 8'h7F;
            end else begin
                seg = 8'($urandom_range(0, 255));
            end
            hold = ($urandom_range(0, 19) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 10);
            drive(en, seg);
            repeat (hold) tick();
            if (it == 150) begin
                sb_on = 1'b0;
                apply_reset();
                sb_on = 1'b1;
            end
        end
        sb_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
